// File: rtl/fifo_byte_packer.sv
// Read-side consumer of a dual-clock FIFO: pops bytes with the FIFO's registered-read
// protocol, packs bytes_per_word bytes (first byte in LSBs) into one word and presents it
// on a valid/ready stream. A flush pulse emits whatever partial word is assembled.
module fifo_byte_packer #(
   parameter int unsigned data_width     = 8,
   parameter int unsigned bytes_per_word = 4,
   parameter int unsigned count_width    = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   fifo_empty,
   output logic                                   fifo_rd_en,
   input  logic [data_width-1:0]                  fifo_dout,
   input  logic                                   flush,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [data_width*bytes_per_word-1:0]   out_data,
   output logic [count_width-1:0]                 out_bytes
);

   localparam int unsigned WordWidth = data_width * bytes_per_word;
   localparam logic [count_width-1:0] CntFull = count_width'(bytes_per_word);

   typedef enum logic {StFill, StFlush} state_e;

   state_e                 state_q, state_d;
   logic [WordWidth-1:0]   asm_q, asm_d;
   logic [count_width-1:0] cnt_q, cnt_d;
   logic                   pending_q, pending_d;
   logic [WordWidth-1:0]   out_data_q, out_data_d;
   logic [count_width-1:0] out_bytes_q, out_bytes_d;
   logic                   out_valid_q, out_valid_d;

   logic                   cnt_full;
   logic                   flush_ready;
   logic                   out_free;
   logic                   xfer;
   logic [count_width:0]   cnt_sum;
   logic [WordWidth-1:0]   word_masked;

   // Transfer decision and FIFO read request.
   always_comb begin
      cnt_full    = (cnt_q == CntFull);
      flush_ready = (state_q == StFlush) && !pending_q && (cnt_q != '0);
      out_free    = !out_valid_q || out_ready;
      xfer        = (cnt_full || flush_ready) && out_free;
      // Bytes held plus the one in flight must leave room for another read.
      cnt_sum     = {1'b0, cnt_q} + {{count_width{1'b0}}, pending_q};
      fifo_rd_en  = !rst && !fifo_empty && (state_q == StFill) &&
                    ((cnt_sum < {1'b0, CntFull}) || (cnt_full && xfer));
   end

   // Assembly register with slots beyond cnt zeroed, as presented on a transfer.
   always_comb begin
      word_masked = '0;
      for (int unsigned k = 0; k < bytes_per_word; k++) begin
         if (count_width'(k) < cnt_q) begin
            word_masked[k*data_width +: data_width] = asm_q[k*data_width +: data_width];
         end
      end
   end

   // Next-state: byte landing, output register, flush state machine.
   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      cnt_d       = cnt_q;
      pending_d   = fifo_rd_en;
      out_data_d  = out_data_q;
      out_bytes_d = out_bytes_q;
      out_valid_d = out_valid_q;

      if (xfer) begin
         out_data_d  = word_masked;
         out_bytes_d = cnt_q;
         out_valid_d = 1'b1;
         cnt_d       = '0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // A byte landing during a transfer starts the next word in slot 0.
      if (pending_q) begin
         for (int unsigned k = 0; k < bytes_per_word; k++) begin
            if (xfer ? (k == 0) : (cnt_q == count_width'(k))) begin
               asm_d[k*data_width +: data_width] = fifo_dout;
            end
         end
         cnt_d = xfer ? count_width'(1) : cnt_q + count_width'(1);
      end

      unique case (state_q)
         StFill: begin
            if (flush) state_d = StFlush;
         end
         StFlush: begin
            if (!pending_q && (cnt_q == '0)) state_d = StFill;
            else if (xfer)                   state_d = StFill;
         end
         default: state_d = StFill;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StFill;
         asm_q       <= '0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         out_data_q  <= '0;
         out_bytes_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         out_data_q  <= out_data_d;
         out_bytes_q <= out_bytes_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Bench for fifo_byte_packer: a registered-read FIFO model feeds the DUT; expected words
// are queued as bytes are pushed and compared as the DUT hands words downstream.
module tb_fifo_byte_packer;

   localparam int unsigned DW  = 8;
   localparam int unsigned BPW = 4;
   localparam int unsigned CW  = 3;
   localparam int unsigned OW  = DW * BPW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [OW-1:0] out_data;
   logic [CW-1:0] out_bytes;

   int checks = 0;
   int errors = 0;

   // FIFO model
   logic [DW-1:0] mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            rd_count = 0;
   logic          empty_force = 1'b0;

   // Scoreboard
   logic [OW-1:0] exp_data_q [$];
   int            exp_bytes_q [$];

   fifo_byte_packer #(
      .data_width     (DW),
      .bytes_per_word (BPW),
      .count_width    (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_bytes  (out_bytes)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr) || empty_force;

   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
         rd_count  <= rd_count + 1;
      end
   end

   // Output monitor: read-while-empty, hold stability, scoreboard compare.
   initial begin
      logic [OW-1:0] hold_data;
      logic [CW-1:0] hold_bytes;
      logic          hold_chk;
      logic [OW-1:0] ed;
      int            eb;
      hold_chk = 1'b0;
      hold_data = '0;
      hold_bytes = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_chk = 1'b0;
         end else begin
            checks++;
            if (fifo_rd_en && fifo_empty) begin
               errors++;
               $display("FAIL rd_en_while_empty: rd_en=%b empty=%b required rd_en=0",
                        fifo_rd_en, fifo_empty);
            end
            if (hold_chk) begin
               checks++;
               if (!out_valid || out_data !== hold_data || out_bytes !== hold_bytes) begin
                  errors++;
                  $display("FAIL hold_stable: got v=%b %h/%0d required v=1 %h/%0d",
                           out_valid, out_data, out_bytes, hold_data, hold_bytes);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_data_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_word: got %h/%0d required no word",
                           out_data, out_bytes);
               end else begin
                  ed = exp_data_q.pop_front();
                  eb = exp_bytes_q.pop_front();
                  if (out_data !== ed || out_bytes !== CW'(eb)) begin
                     errors++;
                     $display("FAIL word: got %h/%0d required %h/%0d",
                              out_data, out_bytes, ed, eb);
                  end
               end
            end
            hold_chk   = out_valid && !out_ready;
            hold_data  = out_data;
            hold_bytes = out_bytes;
         end
      end
   end

   task automatic push_byte(input logic [DW-1:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic push_word(input logic [OW-1:0] w);
      for (int k = 0; k < BPW; k++) push_byte(w[k*DW +: DW]);
      exp_data_q.push_back(w);
      exp_bytes_q.push_back(BPW);
   endtask

   task automatic expect_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_data_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      expect_int("drain_pending_words", exp_data_q.size(), 0);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_bytes !== '0 || fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got v=%b d=%h b=%0d rd=%b required all 0",
                  out_valid, out_data, out_bytes, fifo_rd_en);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_stream;
      int base, lat;
      base = rd_count;
      push_word(32'h04030201);
      push_word(32'h08070605);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      // Pop edge counts as 1, then N+1 cycles to out_valid.
      expect_int("first_word_latency", lat, BPW + 2);
      wait_drain(100);
      expect_int("stream_read_count", rd_count - base, 8);
   endtask

   task automatic test_stall;
      int base;
      base = rd_count;
      out_ready = 1'b0;
      push_word(32'h04030201);
      push_word(32'h08070605);
      push_word(32'h0C0B0A09);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_bytes !== 3'd4) begin
         errors++;
         $display("FAIL stall_hold: got v=%b %h/%0d required v=1 04030201/4",
                  out_valid, out_data, out_bytes);
      end
      expect_int("stall_rd_en", int'(fifo_rd_en), 0);
      expect_int("stall_read_count", rd_count - base, 8);
      out_ready = 1'b1;
      wait_drain(100);
      expect_int("stall_total_reads", rd_count - base, 12);
   endtask

   task automatic test_flush_partial;
      int base, n, guard;
      base = rd_count;
      push_byte(8'hAA);
      push_byte(8'hBB);
      exp_data_q.push_back(32'h0000BBAA);
      exp_bytes_q.push_back(2);
      #1;
      n = 0;
      guard = 0;
      while (n < 2 && guard < 20) begin
         if (fifo_rd_en) n++;
         if (n < 2) begin
            @(posedge clk);
            #1;
         end
         guard++;
      end
      expect_int("flush_reads_seen", n, 2);
      // Second byte is now in flight.
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      push_word(32'h24232221);
      #1;
      expect_int("no_read_in_flush", int'(fifo_rd_en), 0);
      expect_int("flush_read_count", rd_count - base, 2);
      wait_drain(100);
      expect_int("after_flush_reads", rd_count - base, 6);
   endtask

   task automatic test_flush_empty;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_int("empty_flush_no_valid", int'(out_valid), 0);
         @(posedge clk);
         #1;
      end
      push_word(32'h14131211);
      wait_drain(100);
   endtask

   task automatic test_async_reset;
      int base;
      // Mid-word: three bytes assembled, then reset.
      push_byte(8'h51);
      push_byte(8'h52);
      push_byte(8'h53);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_bytes !== '0 || fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_word: got v=%b d=%h b=%0d rd=%b required all 0",
                  out_valid, out_data, out_bytes, fifo_rd_en);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_word(32'h34333231);
      wait_drain(100);

      // Mid-hold: output stalled with a full word behind it, FIFO still holding bytes.
      base = rd_count;
      out_ready = 1'b0;
      push_word(32'h44434241);
      push_word(32'h48474645);
      push_byte(8'h49);
      push_byte(8'h4A);
      push_byte(8'h4B);
      push_byte(8'h4C);
      repeat (20) @(posedge clk);
      #1;
      expect_int("hold_before_reset_valid", int'(out_valid), 1);
      expect_int("hold_before_reset_reads", rd_count - base, 8);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_bytes !== '0 || fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hold: got v=%b d=%h b=%0d rd=%b required all 0",
                  out_valid, out_data, out_bytes, fifo_rd_en);
      end
      exp_data_q.delete();
      exp_bytes_q.delete();
      exp_data_q.push_back(32'h4C4B4A49);
      exp_bytes_q.push_back(4);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      wait_drain(100);
   endtask

   task automatic test_empty_toggle;
      int base, n;
      base = rd_count;
      push_word(32'h63626160);
      push_word(32'h67666564);
      push_word(32'h6B6A6968);
      n = 0;
      while (exp_data_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         empty_force = ~empty_force;
         n++;
      end
      empty_force = 1'b0;
      wait_drain(50);
      expect_int("toggle_read_count", rd_count - base, 12);
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall;
      test_flush_partial;
      test_flush_empty;
      test_async_reset;
      test_empty_toggle;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
